// File: rtl/panda_pkg.sv
// Shared types for the panda load/store unit: access sizes and LSU states.
package panda_pkg;

  // Access size as encoded on req_size_i; 2'b11 is not a legal size.
  typedef enum logic [1:0] {
    MemByte = 2'b00,
    MemHalf = 2'b01,
    MemWord = 2'b10
  } mem_size_e;

  // Request lifecycle: loads pass through LsuCapture, stores skip it,
  // rejected requests go straight to LsuResp.
  typedef enum logic [1:0] {
    LsuIdle,
    LsuAccess,
    LsuCapture,
    LsuResp
  } lsu_state_e;

endpackage

// File: rtl/panda_lsu_align.sv
// Load-data alignment: moves the addressed lane down to bit 0, keeps the
// requested number of bytes and sign- or zero-extends them to a full word.
module panda_lsu_align
  import panda_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Shift by the byte offset, then extract and extend the requested width.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = shifted;
    case (size)
      MemByte: result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      MemHalf: result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/panda_lsu.sv
// Single-outstanding load/store unit in front of a one-cycle-latency SRAM.
// Every output is a register; the RAM port is only active in LsuAccess.
module panda_lsu
  import panda_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 64,
  localparam int AddrW    = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [31:0]          req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 ram_ce_o,
  output logic [3:0]           ram_we_o,
  output logic [AddrW-1:0]     ram_addr_o,
  output logic [DataWidth-1:0] ram_data_o,
  input  logic [DataWidth-1:0] ram_data_i
);

  lsu_state_e           state;
  logic                 lat_we;
  mem_size_e            lat_size;
  logic                 lat_unsigned;
  logic [1:0]           lat_off;

  logic                 req_err;
  logic [3:0]           st_mask;
  logic [DataWidth-1:0] st_data;
  logic [DataWidth-1:0] load_data;

  // Decode the incoming request: legality, store byte lanes and lane-replicated data.
  always_comb begin
    req_err = 1'b0;
    st_mask = 4'b0000;
    st_data = req_wdata_i;
    case (req_size_i)
      MemByte: begin
        st_mask = 4'b0001 << req_addr_i[1:0];
        st_data = {4{req_wdata_i[7:0]}};
      end
      MemHalf: begin
        req_err = req_addr_i[0];
        st_mask = 4'b0011 << req_addr_i[1:0];
        st_data = {2{req_wdata_i[15:0]}};
      end
      MemWord: begin
        req_err = |req_addr_i[1:0];
        st_mask = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr_i[31:2]} >= 32'(Depth)) begin
      req_err = 1'b1;
    end
  end

  panda_lsu_align u_align (
    .rdata       (ram_data_i),
    .offset      (lat_off),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .result      (load_data)
  );

  // Request FSM; RAM strobes and the response are one-cycle pulses cleared by default.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= LsuIdle;
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_err_o    <= 1'b0;
      rsp_rdata_o  <= '0;
      ram_ce_o     <= 1'b0;
      ram_we_o     <= 4'b0000;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
      lat_we       <= 1'b0;
      lat_size     <= MemByte;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 4'b0000;
      ram_addr_o  <= '0;
      ram_data_o  <= '0;
      case (state)
        LsuIdle: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o  <= 1'b0;
            lat_we       <= req_we_i;
            lat_size     <= mem_size_e'(req_size_i);
            lat_unsigned <= req_unsigned_i;
            lat_off      <= req_addr_i[1:0];
            if (req_err) begin
              state       <= LsuResp;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else begin
              state      <= LsuAccess;
              ram_ce_o   <= 1'b1;
              ram_addr_o <= req_addr_i[AddrW+1:2];
              if (req_we_i) begin
                ram_we_o   <= st_mask;
                ram_data_o <= st_data;
              end
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        LsuAccess: begin
          if (lat_we) begin
            state       <= LsuResp;
            rsp_valid_o <= 1'b1;
          end else begin
            state <= LsuCapture;
          end
        end
        LsuCapture: begin
          state       <= LsuResp;
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= load_data;
        end
        LsuResp: begin
          state       <= LsuIdle;
          req_ready_o <= 1'b1;
        end
        default: state <= LsuIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_panda_lsu.sv
// Self-checking bench for panda_lsu with a behavioural word RAM attached.
module tb_panda_lsu;

  localparam int Depth = 64;
  localparam int AddrW = $clog2(Depth);

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_we_i = 1'b0;
  logic [1:0]       req_size_i = 2'b00;
  logic             req_unsigned_i = 1'b0;
  logic [31:0]      req_addr_i = '0;
  logic [31:0]      req_wdata_i = '0;
  logic             req_ready_o;
  logic             rsp_valid_o;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_err_o;
  logic             ram_ce_o;
  logic [3:0]       ram_we_o;
  logic [AddrW-1:0] ram_addr_o;
  logic [31:0]      ram_data_o;
  logic [31:0]      ram_data_i;

  int total = 0;
  int bad = 0;

  panda_lsu #(.DataWidth(32), .Depth(Depth)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .ram_ce_o       (ram_ce_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .ram_data_i     (ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous RAM: byte-lane writes, registered read of the old word.
  logic [31:0] ram [Depth];
  always @(posedge clk_i) begin
    if (ram_ce_o) begin
      for (int j = 0; j < 4; j++) begin
        if (ram_we_o[j]) ram[ram_addr_o][8*j +: 8] <= ram_data_o[8*j +: 8];
      end
      ram_data_i <= ram[ram_addr_o];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %08h want %08h", name, actual, expected);
    end
  endtask

  // Reference model: a byte-addressed memory plus the expected outcome of the
  // request accepted most recently, timed in cycles after its acceptance edge.
  logic [7:0]       model_mem [Depth*4];
  int               cyc = 0;
  bit               pend_active = 1'b0;
  bit               pend_err;
  bit               pend_has_ce;
  int               pend_resp_cyc;
  int               pend_ce_cyc;
  logic [31:0]      pend_rdata;
  logic [31:0]      pend_wdata;
  logic [3:0]       pend_we;
  logic [AddrW-1:0] pend_waddr;

  always @(posedge clk_i or posedge rst_i) begin : model_proc
    int n;
    logic [31:0] a;
    logic [63:0] v;
    if (rst_i) begin
      pend_active = 1'b0;
    end else begin
      cyc++;
      if (req_valid_i && req_ready_o) begin
        a = req_addr_i;
        n = (req_size_i == 2'd0) ? 1 : (req_size_i == 2'd1) ? 2 : (req_size_i == 2'd2) ? 4 : 0;
        pend_active = 1'b1;
        pend_err = 1'b0;
        if (n == 0) pend_err = 1'b1;
        else if ((a % n) != 0) pend_err = 1'b1;
        if ((a / 4) >= Depth) pend_err = 1'b1;
        pend_rdata = '0;
        pend_wdata = '0;
        pend_we = 4'b0000;
        pend_waddr = '0;
        if (pend_err) begin
          pend_has_ce = 1'b0;
          pend_resp_cyc = cyc;
        end else begin
          pend_has_ce = 1'b1;
          pend_ce_cyc = cyc;
          pend_waddr = AddrW'(a / 4);
          if (req_we_i) begin
            for (int k = 0; k < n; k++) begin
              pend_we[(a % 4) + k] = 1'b1;
              model_mem[a + k] = req_wdata_i[8*k +: 8];
            end
            for (int j = 0; j < 4; j++) pend_wdata[8*j +: 8] = req_wdata_i[8*(j % n) +: 8];
            pend_resp_cyc = cyc + 1;
          end else begin
            v = '0;
            for (int k = 0; k < n; k++) v = v | (64'(model_mem[a + k]) << (8*k));
            if (!req_unsigned_i && v[8*n-1]) v = v - (64'd1 << (8*n));
            pend_rdata = v[31:0];
            pend_resp_cyc = cyc + 2;
          end
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk_i) begin : compare_proc
    logic exp_rsp, exp_busy, exp_ce;
    if (rst_i) begin
      checkOutput("rst_ctrl", 32'({req_ready_o, rsp_valid_o, rsp_err_o, ram_ce_o, ram_we_o}), 32'd0);
      checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
      checkOutput("rst_ram", ram_data_o | 32'(ram_addr_o), 32'd0);
    end else begin
      exp_rsp  = pend_active && (cyc == pend_resp_cyc);
      exp_busy = pend_active && (cyc <= pend_resp_cyc);
      exp_ce   = pend_active && pend_has_ce && (cyc == pend_ce_cyc);
      checkOutput("m_ready", 32'(req_ready_o), 32'(!exp_busy));
      checkOutput("m_valid", 32'(rsp_valid_o), 32'(exp_rsp));
      checkOutput("m_err", 32'(rsp_err_o), exp_rsp ? 32'(pend_err) : 32'd0);
      checkOutput("m_rdata", rsp_rdata_o, exp_rsp ? pend_rdata : 32'd0);
      checkOutput("m_ce", 32'(ram_ce_o), 32'(exp_ce));
      checkOutput("m_we", 32'(ram_we_o), exp_ce ? 32'(pend_we) : 32'd0);
      checkOutput("m_addr", 32'(ram_addr_o), exp_ce ? 32'(pend_waddr) : 32'd0);
      checkOutput("m_wdata", ram_data_o, exp_ce ? pend_wdata : 32'd0);
    end
  end

  // Observations of the latest transaction, gathered by awaitResponse.
  int          obs_lat;
  logic        obs_ce_seen;
  logic [3:0]  obs_we;
  logic [31:0] obs_data;
  logic        obs_err;
  logic [31:0] obs_rdata;

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int guard = 0;
    @(negedge clk_i);
    while (!req_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    if (!req_ready_o) begin
      checkOutput("ready_timeout", 32'(req_ready_o), 32'd1);
      return;
    end
    #2;
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic awaitResponse();
    bit got = 1'b0;
    obs_lat = 1;
    obs_ce_seen = 1'b0;
    obs_we = 4'b0000;
    obs_data = '0;
    obs_err = 1'b0;
    obs_rdata = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk_i);
        #1;
        obs_lat++;
      end
      if (ram_ce_o) begin
        obs_ce_seen = 1'b1;
        obs_we = ram_we_o;
        obs_data = ram_data_o;
      end
      if (rsp_valid_o) begin
        got = 1'b1;
        obs_err = rsp_err_o;
        obs_rdata = rsp_rdata_o;
      end
    end
    if (!got) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin : main_proc
    logic seen;
    #1 rst_i = 1'b1;
    #1;
    checkOutput("reset_ready", 32'(req_ready_o), 32'd0);
    checkOutput("reset_rsp", 32'({rsp_valid_o, rsp_err_o}) | rsp_rdata_o, 32'd0);
    checkOutput("reset_ram", 32'({ram_ce_o, ram_we_o}) | ram_data_o | 32'(ram_addr_o), 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1 checkOutput("ready_after_reset", 32'(req_ready_o), 32'd1);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'hA0, 32'hABCDEF89);
    awaitResponse();
    checkOutput("st_word_we", 32'(obs_we), 32'h0000000F);
    checkOutput("st_word_lat", 32'(obs_lat), 32'd2);
    checkOutput("st_word_err", 32'(obs_err), 32'd0);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'hA0, 32'h0);
    awaitResponse();
    checkOutput("ld_word_rdata", obs_rdata, 32'hABCDEF89);
    checkOutput("ld_word_lat", 32'(obs_lat), 32'd3);
    checkOutput("ld_word_we", 32'(obs_we), 32'd0);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'hA7, 32'h12345689);
    awaitResponse();
    checkOutput("st_byte_we", 32'(obs_we), 32'h00000008);
    checkOutput("st_byte_data", obs_data, 32'h89898989);

    applyStimulus(1'b0, 2'b00, 1'b0, 32'hA7, 32'h0);
    awaitResponse();
    checkOutput("ld_byte_signed", obs_rdata, 32'hFFFFFF89);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'hA7, 32'h0);
    awaitResponse();
    checkOutput("ld_byte_unsigned", obs_rdata, 32'h00000089);

    applyStimulus(1'b0, 2'b01, 1'b0, 32'hA2, 32'h0);
    awaitResponse();
    checkOutput("ld_half_signed", obs_rdata, 32'hFFFFABCD);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'hA2, 32'h0);
    awaitResponse();
    checkOutput("ld_half_unsigned", obs_rdata, 32'h0000ABCD);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    awaitResponse();
    checkOutput("mis_word_err", 32'(obs_err), 32'd1);
    checkOutput("mis_word_lat", 32'(obs_lat), 32'd1);
    checkOutput("mis_word_ce", 32'(obs_ce_seen), 32'd0);
    checkOutput("mis_word_rdata", obs_rdata, 32'd0);

    applyStimulus(1'b0, 2'b01, 1'b0, 32'h01, 32'h0);
    awaitResponse();
    checkOutput("mis_half_err", 32'(obs_err), 32'd1);
    checkOutput("mis_half_lat", 32'(obs_lat), 32'd1);
    checkOutput("mis_half_ce", 32'(obs_ce_seen), 32'd0);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    awaitResponse();
    checkOutput("range_err", 32'(obs_err), 32'd1);
    checkOutput("range_ce", 32'(obs_ce_seen), 32'd0);

    applyStimulus(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    awaitResponse();
    checkOutput("size11_err", 32'(obs_err), 32'd1);

    // Reset while a load sits in its capture cycle.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'hA0, 32'h0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("async_rst_ctrl", 32'({req_ready_o, rsp_valid_o, rsp_err_o, ram_ce_o}), 32'd0);
    checkOutput("async_rst_rdata", rsp_rdata_o, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1 seen = seen | rsp_valid_o;
    end
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      seen = seen | rsp_valid_o;
    end
    checkOutput("rst_no_rsp", 32'(seen), 32'd0);
    checkOutput("ready_after_mid_reset", 32'(req_ready_o), 32'd1);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
    awaitResponse();
    checkOutput("post_rst_st_err", 32'(obs_err), 32'd0);
    checkOutput("post_rst_st_lat", 32'(obs_lat), 32'd2);
    checkOutput("post_rst_st_we", 32'(obs_we), 32'h0000000C);
    checkOutput("post_rst_st_data", obs_data, 32'h12341234);

    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    awaitResponse();
    checkOutput("post_rst_ld", obs_rdata, 32'h00001234);

    repeat (3) @(posedge clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
